config_register: RTL and testbench

Memory-mapped configuration and status register bank for the DDR controller. A simple host write/read port programs the DRAM timing parameters, mode-register value and control bits, and the block drives them as static outputs to the command scheduler and init sequencer. It also reports sequencer status back to the host.

---
 rtl/config_register_if.sv | 13 +
 rtl/config_register.sv | 122 ++++++++++++
 tb/tb_config_register.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/config_register_if.sv
// Host register-access bus: one write and/or one read per cycle, registered read data and an error pulse.
interface config_register_if;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (output wr_en, rd_en, addr, wdata, input  rdata, rvalid, err);
  modport slave  (input  wr_en, rd_en, addr, wdata, output rdata, rvalid, err);
endinterface

// File: rtl/config_register.sv
// DDR controller configuration/status register bank.
// Holds the timing, mode and control values and drives them as static outputs.
// Timing/mode writes are locked while the controller is enabled.
module config_register (
  input  logic             clk,
  input  logic             n_rst,        // active-high synchronous reset
  config_register_if.slave bus,
  input  logic             init_done_i,
  input  logic             busy_i,
  output logic             ctrl_enable,
  output logic             init_start,
  output logic             refresh_en,
  output logic [3:0]       t_rcd,
  output logic [3:0]       t_rp,
  output logic [3:0]       t_cl,
  output logic [5:0]       t_ras,
  output logic [15:0]      t_refi,
  output logic [7:0]       t_rfc,
  output logic [12:0]      mode_reg
);
  localparam logic [2:0] A_CTRL = 3'd0, A_TIM0 = 3'd1, A_TIM1 = 3'd2,
                         A_MODE = 3'd3, A_STAT = 3'd4;

  logic        r_ctrl_enable, r_init_start, r_refresh_en;
  logic [3:0]  r_t_rcd, r_t_rp, r_t_cl;
  logic [5:0]  r_t_ras;
  logic [15:0] r_t_refi;
  logic [7:0]  r_t_rfc;
  logic [12:0] r_mode_reg;
  logic [31:0] r_rdata;
  logic        r_rvalid, r_err;

  logic        w_locked_addr, w_wr_err, w_rd_err, w_wr_ok;
  logic [31:0] w_rdata;

  // Timing/mode addresses are the only ones subject to the enable lock.
  assign w_locked_addr = (bus.addr == A_TIM0) || (bus.addr == A_TIM1) || (bus.addr == A_MODE);
  // Lock looks at the enable value held before this edge.
  assign w_wr_err = bus.wr_en && ((bus.addr >= A_STAT) || (w_locked_addr && r_ctrl_enable));
  assign w_rd_err = bus.rd_en && (bus.addr > A_STAT);
  assign w_wr_ok  = bus.wr_en && !w_wr_err;

  // Read mux over the current (pre-write) register contents; unused bits read 0.
  always_comb begin
    w_rdata = '0;
    case (bus.addr)
      A_CTRL: w_rdata = {29'd0, r_refresh_en, 1'b0, r_ctrl_enable};
      A_TIM0: w_rdata = {14'd0, r_t_ras, r_t_cl, r_t_rp, r_t_rcd};
      A_TIM1: w_rdata = {8'd0, r_t_rfc, r_t_refi};
      A_MODE: w_rdata = {19'd0, r_mode_reg};
      A_STAT: w_rdata = {30'd0, busy_i, init_done_i};
      default: w_rdata = '0;
    endcase
  end

  // Configuration registers; zero timing values are stored as 1.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_ctrl_enable <= 1'b0;
      r_init_start  <= 1'b0;
      r_refresh_en  <= 1'b1;
      r_t_rcd       <= 4'd3;
      r_t_rp        <= 4'd3;
      r_t_cl        <= 4'd3;
      r_t_ras       <= 6'd8;
      r_t_refi      <= 16'd780;
      r_t_rfc       <= 8'd44;
      r_mode_reg    <= 13'h0032;
    end else begin
      // init_start fires on any CTRL write with bit1 set, including one that clears enable.
      r_init_start <= w_wr_ok && (bus.addr == A_CTRL) && bus.wdata[1];
      if (w_wr_ok) begin
        case (bus.addr)
          A_CTRL: begin
            r_ctrl_enable <= bus.wdata[0];
            r_refresh_en  <= bus.wdata[2];
          end
          A_TIM0: begin
            r_t_rcd <= (bus.wdata[3:0]   == '0) ? 4'd1 : bus.wdata[3:0];
            r_t_rp  <= (bus.wdata[7:4]   == '0) ? 4'd1 : bus.wdata[7:4];
            r_t_cl  <= (bus.wdata[11:8]  == '0) ? 4'd1 : bus.wdata[11:8];
            r_t_ras <= (bus.wdata[17:12] == '0) ? 6'd1 : bus.wdata[17:12];
          end
          A_TIM1: begin
            r_t_refi <= (bus.wdata[15:0]  == '0) ? 16'd1 : bus.wdata[15:0];
            r_t_rfc  <= (bus.wdata[23:16] == '0) ? 8'd1  : bus.wdata[23:16];
          end
          A_MODE:  r_mode_reg <= bus.wdata[12:0];
          default: ;
        endcase
      end
    end
  end

  // Host response: registered read data (held when idle), valid and merged error pulse.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= bus.rd_en;
      r_err    <= w_wr_err || w_rd_err;
      if (bus.rd_en) r_rdata <= w_rdata;
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.err    = r_err;

  assign ctrl_enable = r_ctrl_enable;
  assign init_start  = r_init_start;
  assign refresh_en  = r_refresh_en;
  assign t_rcd       = r_t_rcd;
  assign t_rp        = r_t_rp;
  assign t_cl        = r_t_cl;
  assign t_ras       = r_t_ras;
  assign t_refi      = r_t_refi;
  assign t_rfc       = r_t_rfc;
  assign mode_reg    = r_mode_reg;
endmodule

// File: tb/tb_config_register.sv
// Bench for config_register: table of single-cycle host accesses with a response
// scoreboard, plus hand sequences for pulses, status sampling, reset and lock.
module tb_config_register;
  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        init_done_i = 1'b0, busy_i = 1'b0;
  logic        ctrl_enable, init_start, refresh_en;
  logic [3:0]  t_rcd, t_rp, t_cl;
  logic [5:0]  t_ras;
  logic [15:0] t_refi;
  logic [7:0]  t_rfc;
  logic [12:0] mode_reg;

  int n_tests = 0;
  int n_fail  = 0;

  config_register_if bus();

  config_register dut (
    .clk(clk), .n_rst(n_rst), .bus(bus),
    .init_done_i(init_done_i), .busy_i(busy_i),
    .ctrl_enable(ctrl_enable), .init_start(init_start), .refresh_en(refresh_en),
    .t_rcd(t_rcd), .t_rp(t_rp), .t_cl(t_cl), .t_ras(t_ras),
    .t_refi(t_refi), .t_rfc(t_rfc), .mode_reg(mode_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        wr;
    logic        rd;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       nm;
    logic        rv;
    logic [31:0] rdata;
    logic        er;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Pop the expected response for the access just clocked and compare the port.
  task automatic check_port();
    sb_t e;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard: empty queue, got 0 expected 1 entry");
    end else begin
      e = sb.pop_front();
      chk({e.nm, ".rvalid"}, {31'd0, bus.rvalid}, {31'd0, e.rv});
      if (e.rv) chk({e.nm, ".rdata"}, bus.rdata, e.rdata);
      chk({e.nm, ".err"}, {31'd0, bus.err}, {31'd0, e.er});
    end
  endtask

  // Apply one cycle of host access at a negedge; check the response one negedge later.
  task automatic drive(input string nm, input logic wr, input logic rd, input logic [2:0] a,
                       input logic [31:0] d, input logic [31:0] erd, input logic eerr);
    sb_t e;
    bus.wr_en = wr; bus.rd_en = rd; bus.addr = a; bus.wdata = d;
    e.nm = nm; e.rv = rd && !n_rst; e.rdata = erd; e.er = eerr && !n_rst;
    sb.push_back(e);
    @(negedge clk);
    check_port();
  endtask

  task automatic idle(input string nm);
    drive(nm, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic chk_reset_cfg(input string p);
    chk({p, ".ctrl_enable"}, {31'd0, ctrl_enable}, 32'd0);
    chk({p, ".init_start"},  {31'd0, init_start},  32'd0);
    chk({p, ".refresh_en"},  {31'd0, refresh_en},  32'd1);
    chk({p, ".t_rcd"},  {28'd0, t_rcd},  32'd3);
    chk({p, ".t_rp"},   {28'd0, t_rp},   32'd3);
    chk({p, ".t_cl"},   {28'd0, t_cl},   32'd3);
    chk({p, ".t_ras"},  {26'd0, t_ras},  32'd8);
    chk({p, ".t_refi"}, {16'd0, t_refi}, 32'd780);
    chk({p, ".t_rfc"},  {24'd0, t_rfc},  32'd44);
    chk({p, ".mode"},   {19'd0, mode_reg}, 32'h32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;

    vecs.push_back('{"rd_ctrl_rst",  0, 1, 3'd0, 32'h0,        32'h4,        0});
    vecs.push_back('{"rd_tim0_rst",  0, 1, 3'd1, 32'h0,        32'h8333,     0});
    vecs.push_back('{"rd_tim1_rst",  0, 1, 3'd2, 32'h0,        32'h2C030C,   0});
    vecs.push_back('{"rd_mode_rst",  0, 1, 3'd3, 32'h0,        32'h32,       0});
    vecs.push_back('{"rd_stat0",     0, 1, 3'd4, 32'h0,        32'h0,        0});
    vecs.push_back('{"wr_tim0",      1, 0, 3'd1, 32'hFFFCA545, 32'h0,        0});
    vecs.push_back('{"rd_tim0",      0, 1, 3'd1, 32'h0,        32'hA545,     0});
    vecs.push_back('{"wr_mode",      1, 0, 3'd3, 32'hFFFFE123, 32'h0,        0});
    vecs.push_back('{"rd_mode",      0, 1, 3'd3, 32'h0,        32'h123,      0});
    vecs.push_back('{"wr_tim1_zero", 1, 0, 3'd2, 32'h0,        32'h0,        0});
    vecs.push_back('{"rd_tim1_clmp", 0, 1, 3'd2, 32'h0,        32'h00010001, 0});
    vecs.push_back('{"wr_tim0_zero", 1, 0, 3'd1, 32'h0,        32'h0,        0});
    vecs.push_back('{"rd_tim0_clmp", 0, 1, 3'd1, 32'h0,        32'h1111,     0});
    vecs.push_back('{"wrrd_same",    1, 1, 3'd1, 32'h0000A545, 32'h1111,     0});
    vecs.push_back('{"rd_after_wr",  0, 1, 3'd1, 32'h0,        32'hA545,     0});
    vecs.push_back('{"wr_tim1",      1, 0, 3'd2, 32'h00100200, 32'h0,        0});
    vecs.push_back('{"rd_tim1",      0, 1, 3'd2, 32'h0,        32'h00100200, 0});
    vecs.push_back('{"wr_ctrl_en",   1, 0, 3'd0, 32'h1,        32'h0,        0});
    vecs.push_back('{"rd_ctrl_en",   0, 1, 3'd0, 32'h0,        32'h1,        0});
    vecs.push_back('{"wr_tim1_lock", 1, 0, 3'd2, 32'h00ABCDEF, 32'h0,        1});
    vecs.push_back('{"rd_tim1_lock", 0, 1, 3'd2, 32'h0,        32'h00100200, 0});
    vecs.push_back('{"wr_tim0_lock", 1, 0, 3'd1, 32'h1234,     32'h0,        1});
    vecs.push_back('{"wr_mode_lock", 1, 0, 3'd3, 32'h1,        32'h0,        1});
    vecs.push_back('{"rd_tim0_lock", 0, 1, 3'd1, 32'h0,        32'hA545,     0});
    vecs.push_back('{"rd_mode_lock", 0, 1, 3'd3, 32'h0,        32'h123,      0});
    vecs.push_back('{"rd_rsv6",      0, 1, 3'd6, 32'h0,        32'h0,        1});
    vecs.push_back('{"rd_rsv5",      0, 1, 3'd5, 32'h0,        32'h0,        1});
    vecs.push_back('{"rd_rsv7",      0, 1, 3'd7, 32'h0,        32'h0,        1});
    vecs.push_back('{"wr_stat",      1, 0, 3'd4, 32'hF,        32'h0,        1});
    vecs.push_back('{"wr_rsv7",      1, 0, 3'd7, 32'hF,        32'h0,        1});
    vecs.push_back('{"wrrd_rsv",     1, 1, 3'd6, 32'hF,        32'h0,        1});
    vecs.push_back('{"wrrd_stat",    1, 1, 3'd4, 32'h3,        32'h0,        1});
    vecs.push_back('{"wr_ctrl_dis",  1, 0, 3'd0, 32'h4,        32'h0,        0});
    vecs.push_back('{"rd_ctrl_dis",  0, 1, 3'd0, 32'h0,        32'h4,        0});
    vecs.push_back('{"wr_tim0_b",    1, 0, 3'd1, 32'h2345,     32'h0,        0});
    vecs.push_back('{"rd_tim0_b",    0, 1, 3'd1, 32'h0,        32'h2345,     0});

    // Reset for two cycles, then check the idle port and reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst.err",    {31'd0, bus.err},    32'd0);
    chk("rst.rdata",  bus.rdata,           32'd0);
    chk_reset_cfg("rst");
    n_rst = 1'b0;

    foreach (vecs[i])
      drive(vecs[i].nm, vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d,
            vecs[i].exp_rdata, vecs[i].exp_err);

    // Static outputs after the table.
    chk("cfg.t_rcd",  {28'd0, t_rcd},  32'd5);
    chk("cfg.t_rp",   {28'd0, t_rp},   32'd4);
    chk("cfg.t_cl",   {28'd0, t_cl},   32'd3);
    chk("cfg.t_ras",  {26'd0, t_ras},  32'd2);
    chk("cfg.t_refi", {16'd0, t_refi}, 32'h200);
    chk("cfg.t_rfc",  {24'd0, t_rfc},  32'h10);
    chk("cfg.mode",   {19'd0, mode_reg}, 32'h123);
    chk("cfg.ctrl_enable", {31'd0, ctrl_enable}, 32'd0);
    chk("cfg.refresh_en",  {31'd0, refresh_en},  32'd1);

    // init_start pulse: exactly one cycle, CTRL bit1 reads back 0.
    drive("wr_ctrl_3", 1, 0, 3'd0, 32'h3, 32'h0, 0);
    chk("pulse.init_start_hi", {31'd0, init_start},  32'd1);
    chk("pulse.ctrl_enable",   {31'd0, ctrl_enable}, 32'd1);
    idle("pulse_idle");
    chk("pulse.init_start_lo", {31'd0, init_start},  32'd0);
    drive("rd_ctrl_3", 0, 1, 3'd0, 32'h0, 32'h1, 0);

    // A CTRL write that clears enable still fires init_start.
    drive("wr_ctrl_2", 1, 0, 3'd0, 32'h2, 32'h0, 0);
    chk("clr.init_start_hi", {31'd0, init_start},  32'd1);
    chk("clr.ctrl_enable",   {31'd0, ctrl_enable}, 32'd0);
    idle("clr_idle");
    chk("clr.init_start_lo", {31'd0, init_start},  32'd0);

    // Status is sampled at the read edge.
    init_done_i = 1'b1; busy_i = 1'b0;
    drive("rd_stat_1", 0, 1, 3'd4, 32'h0, 32'h1, 0);
    busy_i = 1'b1;
    drive("rd_stat_3", 0, 1, 3'd4, 32'h0, 32'h3, 0);
    init_done_i = 1'b0; busy_i = 1'b0;
    idle("stat_idle");
    chk("stat.rdata_hold", bus.rdata, 32'h3);

    // Reset takes priority over accesses and cancels init_start.
    n_rst = 1'b1;
    drive("rst_rd",     0, 1, 3'd1, 32'h0, 32'h0, 0);
    drive("rst_rd_rsv", 0, 1, 3'd6, 32'h0, 32'h0, 1);
    drive("rst_wr_ctl", 1, 0, 3'd0, 32'h3, 32'h0, 0);
    chk("rst2.rdata", bus.rdata, 32'd0);
    chk_reset_cfg("rst2");
    n_rst = 1'b0;

    // Lock from reset values: TIMING1 write dropped with an err pulse.
    drive("lk_wr_ctrl", 1, 0, 3'd0, 32'h1,        32'h0, 0);
    drive("lk_wr_tim1", 1, 0, 3'd2, 32'h00100200, 32'h0, 1);
    idle("lk_idle");
    chk("lk.err_one_cycle", {31'd0, bus.err}, 32'd0);
    chk("lk.t_refi", {16'd0, t_refi}, 32'd780);
    chk("lk.t_rfc",  {24'd0, t_rfc},  32'd44);
    drive("lk_rd_tim1", 0, 1, 3'd2, 32'h0, 32'h2C030C, 0);
    idle("end_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
